// File: rtl/imm_encoder.sv
// Iterative encoder from a 32-bit constant to the 12-bit {rot, imm8} rotated immediate.
// Tries one even rotation per cycle, optionally also on the complement for MOV/MVN swaps.
module imm_encoder #(
    parameter bit CHECK_INVERTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        allow_inv,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        inverted,
    output logic [11:0] shift_operand
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned SW = RW + IW;
    localparam int unsigned AW = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [RW-1:0]   r_rot_cnt;
    logic [DW-1:0]   r_val_q;
    logic            r_inv_q;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic            r_inverted;
    logic [SW-1:0]   r_shift_operand;

    state_t          w_state_nxt;
    logic [RW-1:0]   w_rot_nxt;
    logic [DW-1:0]   w_val_nxt;
    logic            w_inv_q_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            w_valid_nxt;
    logic            w_inverted_nxt;
    logic [SW-1:0]   w_shift_nxt;

    logic [AW-1:0]   w_lshamt;
    logic [AW-1:0]   w_rshamt;
    logic [DW-1:0]   w_cand;
    logic [DW-1:0]   w_icand;
    logic            w_dir_hit;
    logic            w_inv_hit;

    // ROL by 2r; a zero rotation shifts right by the full width, which yields 0.
    assign w_lshamt  = AW'({r_rot_cnt, 1'b0});
    assign w_rshamt  = AW'(DW) - w_lshamt;
    assign w_cand    = (r_val_q << w_lshamt) | (r_val_q >> w_rshamt);
    // Rotation commutes with complement, so the inverted candidate is just ~cand.
    assign w_icand   = ~w_cand;
    assign w_dir_hit = (w_cand[DW-1:IW] == '0);
    assign w_inv_hit = CHECK_INVERTED && r_inv_q && !w_dir_hit && (w_icand[DW-1:IW] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_rot_cnt       <= '0;
            r_val_q         <= '0;
            r_inv_q         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_valid         <= 1'b0;
            r_inverted      <= 1'b0;
            r_shift_operand <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_rot_cnt       <= w_rot_nxt;
            r_val_q         <= w_val_nxt;
            r_inv_q         <= w_inv_q_nxt;
            r_busy          <= w_busy_nxt;
            r_done          <= w_done_nxt;
            r_valid         <= w_valid_nxt;
            r_inverted      <= w_inverted_nxt;
            r_shift_operand <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rot_nxt      = r_rot_cnt;
        w_val_nxt      = r_val_q;
        w_inv_q_nxt    = r_inv_q;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_valid_nxt    = r_valid;
        w_inverted_nxt = r_inverted;
        w_shift_nxt    = r_shift_operand;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_SEARCH;
                    w_val_nxt      = value;
                    w_inv_q_nxt    = allow_inv;
                    w_rot_nxt      = '0;
                    w_busy_nxt     = 1'b1;
                    w_valid_nxt    = 1'b0;
                    w_inverted_nxt = 1'b0;
                    w_shift_nxt    = '0;
                end
            end
            ST_SEARCH: begin
                // Lowest rotation wins; direct is tested before inverted at each r.
                if (w_dir_hit) begin
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_inverted_nxt = 1'b0;
                    w_shift_nxt    = {r_rot_cnt, w_cand[IW-1:0]};
                end else if (w_inv_hit) begin
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_inverted_nxt = 1'b1;
                    w_shift_nxt    = {r_rot_cnt, w_icand[IW-1:0]};
                end else if (r_rot_cnt == '1) begin
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                    w_valid_nxt    = 1'b0;
                    w_inverted_nxt = 1'b0;
                    w_shift_nxt    = '0;
                end else begin
                    w_rot_nxt      = r_rot_cnt + RW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign valid         = r_valid;
    assign inverted      = r_inverted;
    assign shift_operand = r_shift_operand;

endmodule
